rst_seq_gen: RTL and testbench
==============================

# rst_seq_gen

Parametrised reset sequencer generating NUM_OUT active-low reset outputs from the debounced board reset, released in a fixed order after a lock-qualified hold period. Successor to the single-output 50 ms reset stretcher: multiple domains (PHY, SoC, PTP, MAC), staggered release, re-sequencing on PLL lock loss or software request, and a restart counter. Sits at top level between the antibounce stage and all downstream reset consumers.

## Interface
- NUM_OUT, 4, number of reset outputs (1..16); index 0 released first
- HOLD_CYCLES, 2500000, lock-qualified hold before first release (≥1; 50 ms at 50 MHz)
- STEP_CYCLES, 50000, delay between successive releases (≥1; 1 ms)
- c10_clk50m  in  1  clock
- clean_rst_long_n  in  1  reset, asynchronous, active-low
- pll_locked_i  in  1  asynchronous lock indicator; low forces re-sequence
- soft_rst_req_i  in  1  asynchronous software request; rising edge forces re-sequence
- rst_n_o  out  NUM_OUT  per-domain active-low resets
- seq_done_o  out  1  high when all outputs released
- state_o  out  2  0=HOLD, 1=RELEASE, 2=RUN
- restart_cnt_o  out  8  saturating count of re-sequences

## Operation
- Inputs pass through 2-FF synchronizers (reset to 0) giving locked_s, soft_s; soft_d = soft_s delayed one cycle; soft_rise = soft_s & ~soft_d.
- Single counter cnt, width $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1); release index k, width $clog2(NUM_OUT+1).
- HOLD: all rst_n_o = 0. locked_s=1: cnt++ ; locked_s=0: cnt=0. soft_rise: cnt=0. When locked_s=1 and cnt==HOLD_CYCLES-1: rst_n_o[0]=1, cnt=0, k=1, -> RELEASE (or -> RUN with seq_done_o=1 if NUM_OUT==1).
- RELEASE: cnt++ each cycle; at cnt==STEP_CYCLES-1: rst_n_o[k]=1, cnt=0, k++; if k was NUM_OUT-1 -> RUN, seq_done_o=1 same edge.
- RUN: outputs held; cnt idle.
- Abort (RELEASE or RUN): locked_s==0 or soft_rise -> HOLD; all rst_n_o=0, seq_done_o=0, cnt=0, k=0, restart_cnt_o++ (saturate at 255). Abort has priority over release step in the same cycle.
- soft_rise or lock loss while already in HOLD: restarts hold count only, restart_cnt_o unchanged.
- Released outputs never deassert individually; only abort or reset lowers them, always all together.

## Timing
- During clean_rst_long_n=0 (asynchronous): rst_n_o=0 (all), seq_done_o=0, state_o=0, restart_cnt_o=0, cnt=0, k=0, synchronizers=0. Outputs asserted immediately, not after first clock.
- Input-to-action latency: change before edge n -> synchronizer at n, n+1 -> FSM acts at edge n+2; outputs change after edge n+2.
- With pll_locked_i high through reset release: first counting edge is edge 3 after release; rst_n_o[0] rises after edge 2+HOLD_CYCLES; rst_n_o[j] rises STEP_CYCLES edges after rst_n_o[j-1].
- soft_rst_req_i held high: single re-sequence; re-arm needs low for ≥1 synchronized cycle.
- Lock glitch shorter than one clock may be missed; not required to be caught.
- All outputs registered; no combinational path input -> output.

## Test plan
- HOLD=10, STEP=4, NUM_OUT=3, locked_i=1 from t0, release reset at edge 0 -> rst_n_o=3'b001 after edge 12, 3'b011 after 16, 3'b111 and seq_done_o=1 after 20, state_o=2.
- Assert clean_rst_long_n=0 mid-RELEASE (between clock edges) -> rst_n_o=0, state_o=0, restart_cnt_o=0 immediately, without clock edge.
- In RUN, drop pll_locked_i before edge n -> rst_n_o=0, seq_done_o=0, restart_cnt_o=1 after edge n+2; raise lock -> full sequence repeats with same spacing.
- In HOLD, toggle locked_i low 3 cycles at cnt=7 -> cnt restarts, rst_n_o[0] rises 10 counting edges after lock resynced; restart_cnt_o unchanged.
- soft_rst_req_i pulse in RELEASE coinciding with a release-step edge -> abort wins, rst_n_o=0; hold soft high 100 cycles -> exactly one restart counted.
- 300 forced restarts -> restart_cnt_o saturates at 255, no wrap.

Source files
------------

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds every downstream domain in reset until the PLL has
// been locked for a qualified hold period, then releases the domains one by
// one in index order. Lock loss or a software request re-runs the sequence.
`timescale 1ns/1ps

module rst_seq_gen #(
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 2500000,
    parameter int STEP_CYCLES = 50000
) (
    input  logic               c10_clk50m,
    input  logic               clean_rst_long_n,
    input  logic               pll_locked_i,
    input  logic               soft_rst_req_i,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic               seq_done_o,
    output logic [1:0]         state_o,
    output logic [7:0]         restart_cnt_o
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int K_W        = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [K_W-1:0]     K_LAST    = K_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] ONE_HOT0  = NUM_OUT'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [K_W-1:0]     k;
    logic [NUM_OUT-1:0] rst_q;
    logic               seq_done;
    logic [7:0]         restart_cnt;

    logic locked_meta, locked_s;
    logic soft_meta, soft_s, soft_d;
    logic soft_rise;

    // Two-flop synchronizers for the asynchronous lock and request inputs,
    // plus one extra stage on the request for edge detection.
    always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
        if (!clean_rst_long_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
            soft_meta   <= 1'b0;
            soft_s      <= 1'b0;
            soft_d      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, which is what gives a real 2-flop chain.
            locked_meta <= pll_locked_i;
            locked_s    <= locked_meta;
            soft_meta   <= soft_rst_req_i;
            soft_s      <= soft_meta;
            soft_d      <= soft_s;
        end
    end

    // A held-high request yields a single pulse; re-arming needs a low cycle.
    assign soft_rise = soft_s & ~soft_d;

    // Sequencer FSM: hold count, staggered release, abort on lock loss/request.
    always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
        if (!clean_rst_long_n) begin
            state       <= ST_HOLD;
            cnt         <= '0;
            k           <= '0;
            rst_q       <= '0;
            seq_done    <= 1'b0;
            restart_cnt <= 8'd0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (locked_s && !soft_rise) begin
                        if (cnt == HOLD_LAST) begin
                            rst_q[0] <= 1'b1;
                            cnt      <= '0;
                            k        <= K_W'(1);
                            if (NUM_OUT == 1) begin
                                state    <= ST_RUN;
                                seq_done <= 1'b1;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // Lock loss or request while holding only restarts the count.
                        cnt <= '0;
                    end
                end

                ST_RELEASE, ST_RUN: begin
                    // NOTE: the abort branch is tested first so it overrides a
                    // release step landing on the same edge.
                    if (!locked_s || soft_rise) begin
                        state    <= ST_HOLD;
                        rst_q    <= '0;
                        seq_done <= 1'b0;
                        cnt      <= '0;
                        k        <= '0;
                        if (restart_cnt != 8'hFF) begin
                            restart_cnt <= restart_cnt + 8'd1;
                        end
                    end else if (state == ST_RELEASE) begin
                        if (cnt == STEP_LAST) begin
                            rst_q <= rst_q | (ONE_HOT0 << k);
                            cnt   <= '0;
                            k     <= k + 1'b1;
                            if (k == K_LAST) begin
                                state    <= ST_RUN;
                                seq_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_HOLD;
                    rst_q <= '0;
                    cnt   <= '0;
                    k     <= '0;
                end
            endcase
        end
    end

    // Every output comes straight from a flop.
    assign rst_n_o       = rst_q;
    assign seq_done_o    = seq_done;
    assign state_o       = state;
    assign restart_cnt_o = restart_cnt;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen with HOLD=10, STEP=4, NUM_OUT=3.
`timescale 1ns/1ps

module tb_rst_seq_gen;

    localparam int NUM_OUT = 3;
    localparam int HOLD    = 10;
    localparam int STEP    = 4;

    logic               c10_clk50m;
    logic               clean_rst_long_n;
    logic               pll_locked_i;
    logic               soft_rst_req_i;
    logic [NUM_OUT-1:0] rst_n_o;
    logic               seq_done_o;
    logic [1:0]         state_o;
    logic [7:0]         restart_cnt_o;

    int total = 0;
    int bad   = 0;

    rst_seq_gen #(
        .NUM_OUT     (NUM_OUT),
        .HOLD_CYCLES (HOLD),
        .STEP_CYCLES (STEP)
    ) dut (
        .c10_clk50m       (c10_clk50m),
        .clean_rst_long_n (clean_rst_long_n),
        .pll_locked_i     (pll_locked_i),
        .soft_rst_req_i   (soft_rst_req_i),
        .rst_n_o          (rst_n_o),
        .seq_done_o       (seq_done_o),
        .state_o          (state_o),
        .restart_cnt_o    (restart_cnt_o)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial c10_clk50m = 1'b0;
    always #5 c10_clk50m = ~c10_clk50m;

    // Hard time limit so the run can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_rst, input logic e_done,
                             input logic [1:0] e_state, input logic [7:0] e_restart);
        check({tag, ".rst"},     32'(rst_n_o),       32'(e_rst));
        check({tag, ".done"},    32'(seq_done_o),    32'(e_done));
        check({tag, ".state"},   32'(state_o),       32'(e_state));
        check({tag, ".restart"}, 32'(restart_cnt_o), 32'(e_restart));
    endtask

    // Advance n rising edges and sample 1 ns later; inputs set afterwards
    // are seen as changing before the next edge.
    task automatic edges(input int n);
        repeat (n) @(posedge c10_clk50m);
        #1;
    endtask

    initial begin
        clean_rst_long_n = 1'b0;
        pll_locked_i     = 1'b1;
        soft_rst_req_i   = 1'b0;

        // Reset state
        edges(3);
        check_all("reset", 3'b000, 1'b0, 2'd0, 8'd0);

        // Release reset before edge 1: counting from edge 3, rst0 at 12.
        clean_rst_long_n = 1'b1;
        edges(11);  check_all("e11", 3'b000, 1'b0, 2'd0, 8'd0);
        edges(1);   check_all("e12", 3'b001, 1'b0, 2'd1, 8'd0);
        edges(3);   check_all("e15", 3'b001, 1'b0, 2'd1, 8'd0);
        edges(1);   check_all("e16", 3'b011, 1'b0, 2'd1, 8'd0);
        edges(3);   check_all("e19", 3'b011, 1'b0, 2'd1, 8'd0);
        edges(1);   check_all("e20", 3'b111, 1'b1, 2'd2, 8'd0);

        // Lock loss in RUN: acts two edges after the first sampling edge.
        pll_locked_i = 1'b0;
        edges(1);   check_all("lk_n0", 3'b111, 1'b1, 2'd2, 8'd0);
        edges(1);   check_all("lk_n1", 3'b111, 1'b1, 2'd2, 8'd0);
        edges(1);   check_all("lk_n2", 3'b000, 1'b0, 2'd0, 8'd1);

        // Relock before edge m; hold counter reaches 7 after edge m+8.
        pll_locked_i = 1'b1;
        edges(9);   check_all("hold_c7", 3'b000, 1'b0, 2'd0, 8'd1);
        // Lock low for 3 cycles, raised again before edge m+12.
        pll_locked_i = 1'b0;
        edges(3);   check_all("glitch_m11", 3'b000, 1'b0, 2'd0, 8'd1);
        pll_locked_i = 1'b1;
        // Restarted count: rst0 at m+23, then same step spacing.
        edges(11);  check_all("re_m22", 3'b000, 1'b0, 2'd0, 8'd1);
        edges(1);   check_all("re_r0", 3'b001, 1'b0, 2'd1, 8'd1);
        edges(3);   check_all("re_r3", 3'b001, 1'b0, 2'd1, 8'd1);
        edges(1);   check_all("re_r4", 3'b011, 1'b0, 2'd1, 8'd1);
        edges(3);   check_all("re_r7", 3'b011, 1'b0, 2'd1, 8'd1);
        edges(1);   check_all("re_r8", 3'b111, 1'b1, 2'd2, 8'd1);

        // One-cycle soft pulse from RUN: abort 3 edges after it goes high.
        soft_rst_req_i = 1'b1;
        edges(1);   soft_rst_req_i = 1'b0;
        edges(1);   check_all("sp_a2", 3'b111, 1'b1, 2'd2, 8'd1);
        edges(1);   check_all("sp_a3", 3'b000, 1'b0, 2'd0, 8'd2);
        edges(9);   check_all("sp_a12", 3'b000, 1'b0, 2'd0, 8'd2);
        edges(1);   check_all("sp_a13", 3'b001, 1'b0, 2'd1, 8'd2);

        // Soft pulse whose rise lands on the rst1 step edge: abort wins.
        edges(1);   soft_rst_req_i = 1'b1;
        edges(1);   soft_rst_req_i = 1'b0;
        edges(1);   check_all("coin_r3", 3'b001, 1'b0, 2'd1, 8'd2);
        edges(1);   check_all("coin_r4", 3'b000, 1'b0, 2'd0, 8'd3);

        // Back to RUN, then hold soft high for 100 cycles: one restart only.
        edges(18);  check_all("run_b18", 3'b111, 1'b1, 2'd2, 8'd3);
        soft_rst_req_i = 1'b1;
        edges(3);   check_all("hold_s3", 3'b000, 1'b0, 2'd0, 8'd4);
        edges(97);  check_all("hold_s100", 3'b111, 1'b1, 2'd2, 8'd4);
        soft_rst_req_i = 1'b0;
        edges(5);   check_all("soft_fall", 3'b111, 1'b1, 2'd2, 8'd4);

        // Re-armed request works again; land mid-RELEASE.
        soft_rst_req_i = 1'b1;
        edges(1);   soft_rst_req_i = 1'b0;
        edges(14);  check_all("rearm_rel", 3'b001, 1'b0, 2'd1, 8'd5);

        // Asynchronous reset between edges takes effect without a clock.
        #2;
        clean_rst_long_n = 1'b0;
        #1;
        check_all("async_rst", 3'b000, 1'b0, 2'd0, 8'd0);

        // 300 forced restarts: counter must stick at 255.
        edges(1);
        clean_rst_long_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int w;
            w = 0;
            while (rst_n_o[0] !== 1'b1 && w < 40) begin
                edges(1);
                w++;
            end
            check("sat_release", 32'(rst_n_o[0]), 32'd1);
            if (w >= 40) break;
            soft_rst_req_i = 1'b1;
            edges(1);
            soft_rst_req_i = 1'b0;
            edges(2);
            if (i == 253) check("sat_254", 32'(restart_cnt_o), 32'd254);
            if (i == 254) check("sat_255", 32'(restart_cnt_o), 32'd255);
            if (i == 299) check("sat_300", 32'(restart_cnt_o), 32'd255);
        end
        check("sat_state", 32'(state_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
